// File: rtl/decode_stage.sv
// Registered decode stage for a small RISC-V subset (ld/sd/and/or/add/sub/beq)
// with a one-entry output buffer, load-use stall insertion and flush.
module decode_stage #(
  parameter int DADDR_W  = 5,
  parameter int BOFF_W   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               reg_write_enable,
  output logic [4:0]         reg_read_addr_1,
  output logic [4:0]         reg_read_addr_2,
  output logic [4:0]         reg_write_addr,
  output logic               data_write_enable,
  output logic [DADDR_W-1:0] data_read_addr,
  output logic [DADDR_W-1:0] data_write_addr,
  output logic [1:0]         alu_ctrl,
  output logic               reg_write_select,
  output logic               branch,
  output logic [BOFF_W-1:0]  branch_offset,
  output logic               illegal,
  output logic [1:0]         dbg_state
);

  // Handshake: a word transfers on any cycle where valid && ready are both high
  // at the rising edge; a producer holding valid keeps its data stable until then.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_STALL = 2'd2} state_t;

  state_t r_state, w_next_state;
  logic [2:0] r_cnt, w_next_cnt;

  logic               r_rwe, r_dwe, r_sel, r_br, r_ill;
  logic [4:0]         r_ra1, r_ra2, r_wa;
  logic [DADDR_W-1:0] r_dra, r_dwa;
  logic [1:0]         r_alu;
  logic [BOFF_W-1:0]  r_boff;

  logic               w_rwe, w_dwe, w_sel, w_br, w_ill;
  logic [4:0]         w_ra1, w_ra2, w_wa;
  logic [DADDR_W-1:0] w_dra, w_dwa;
  logic [1:0]         w_alu;
  logic [BOFF_W-1:0]  w_boff;

  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic       w_hazard, w_accept, w_held_ld;

  assign w_op = inst[6:0];
  assign w_f3 = inst[14:12];
  assign w_f7 = inst[31:25];

  always_comb begin
    w_rwe  = 1'b0;
    w_dwe  = 1'b0;
    w_sel  = 1'b0;
    w_br   = 1'b0;
    w_ill  = 1'b0;
    w_ra1  = '0;
    w_ra2  = '0;
    w_wa   = '0;
    w_dra  = '0;
    w_dwa  = '0;
    w_alu  = '0;
    w_boff = '0;
    if (w_f3 == 3'b011 && w_op == 7'b0000011) begin
      w_rwe = 1'b1;
      w_wa  = inst[11:7];
      w_dra = DADDR_W'(inst[19:15]) + DADDR_W'(inst[24:20]);
    end else if (w_f3 == 3'b011 && w_op == 7'b0100011) begin
      w_dwe = 1'b1;
      w_ra1 = inst[24:20];
      w_dwa = DADDR_W'(inst[19:15]) + DADDR_W'(inst[11:7]);
    end else if (w_op == 7'b0110011 &&
                 ((w_f7 == 7'b0000000 && (w_f3 == 3'b111 || w_f3 == 3'b110 || w_f3 == 3'b000)) ||
                  (w_f7 == 7'b0100000 && w_f3 == 3'b000))) begin
      w_rwe = 1'b1;
      w_sel = 1'b1;
      w_ra1 = inst[19:15];
      w_ra2 = inst[24:20];
      w_wa  = inst[11:7];
      if (w_f3 == 3'b111)      w_alu = 2'b00;
      else if (w_f3 == 3'b110) w_alu = 2'b01;
      else if (w_f7[5])        w_alu = 2'b11;
      else                     w_alu = 2'b10;
    end else if (w_f3 == 3'b000 && w_op == 7'b1100011) begin
      w_br   = 1'b1;
      w_alu  = 2'b11;
      w_ra1  = inst[19:15];
      w_ra2  = inst[24:20];
      w_boff = BOFF_W'({inst[25], inst[11:9]});
    end else begin
      w_ill = 1'b1;
    end
  end

  // Only ld writes the register file from memory; illegal words never set rwe.
  assign w_held_ld = r_rwe && !r_sel;
  assign w_hazard  = in_valid && out_valid && out_ready && w_held_ld && (r_wa != 5'd0) &&
                     ((w_ra1 == r_wa) || (w_ra2 == r_wa));

  always_comb begin
    out_valid = (r_state == S_FULL);
    in_ready  = 1'b0;
    if (!rst && !flush) begin
      if (r_state == S_EMPTY)     in_ready = 1'b1;
      else if (r_state == S_FULL) in_ready = out_ready && !w_hazard;
    end
  end

  assign w_accept  = in_valid && in_ready;
  assign dbg_state = r_state;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (flush) begin
      w_next_state = S_EMPTY;
      w_next_cnt   = 3'd0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_next_state = S_FULL;
        S_FULL: begin
          if (out_ready) begin
            if (w_hazard) begin
              w_next_state = S_STALL;
              w_next_cnt   = 3'd0;
            end else if (!w_accept) begin
              w_next_state = S_EMPTY;
            end
          end
        end
        S_STALL: begin
          if (r_cnt == 3'(LOAD_LAT - 1)) begin
            w_next_state = S_EMPTY;
            w_next_cnt   = 3'd0;
          end else begin
            w_next_cnt = r_cnt + 3'd1;
          end
        end
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_cnt   <= 3'd0;
      r_rwe   <= 1'b0;
      r_dwe   <= 1'b0;
      r_sel   <= 1'b0;
      r_br    <= 1'b0;
      r_ill   <= 1'b0;
      r_ra1   <= '0;
      r_ra2   <= '0;
      r_wa    <= '0;
      r_dra   <= '0;
      r_dwa   <= '0;
      r_alu   <= '0;
      r_boff  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_rwe  <= w_rwe;
        r_dwe  <= w_dwe;
        r_sel  <= w_sel;
        r_br   <= w_br;
        r_ill  <= w_ill;
        r_ra1  <= w_ra1;
        r_ra2  <= w_ra2;
        r_wa   <= w_wa;
        r_dra  <= w_dra;
        r_dwa  <= w_dwa;
        r_alu  <= w_alu;
        r_boff <= w_boff;
      end
    end
  end

  assign reg_write_enable  = r_rwe;
  assign reg_read_addr_1   = r_ra1;
  assign reg_read_addr_2   = r_ra2;
  assign reg_write_addr    = r_wa;
  assign data_write_enable = r_dwe;
  assign data_read_addr    = r_dra;
  assign data_write_addr   = r_dwa;
  assign alu_ctrl          = r_alu;
  assign reg_write_select  = r_sel;
  assign branch            = r_br;
  assign branch_offset     = r_boff;
  assign illegal           = r_ill;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the stage.
module tb_decode_stage;
  localparam int DADDR_W  = 5;
  localparam int BOFF_W   = 5;
  localparam int LOAD_LAT = 2;

  logic               clk = 1'b0;
  logic               rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]        inst;
  logic               reg_write_enable, data_write_enable, reg_write_select, branch, illegal;
  logic [4:0]         reg_read_addr_1, reg_read_addr_2, reg_write_addr;
  logic [DADDR_W-1:0] data_read_addr, data_write_addr;
  logic [1:0]         alu_ctrl, dbg_state;
  logic [BOFF_W-1:0]  branch_offset;

  decode_stage #(.DADDR_W(DADDR_W), .BOFF_W(BOFF_W), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .reg_write_enable(reg_write_enable), .reg_read_addr_1(reg_read_addr_1),
    .reg_read_addr_2(reg_read_addr_2), .reg_write_addr(reg_write_addr),
    .data_write_enable(data_write_enable), .data_read_addr(data_read_addr),
    .data_write_addr(data_write_addr), .alu_ctrl(alu_ctrl),
    .reg_write_select(reg_write_select), .branch(branch),
    .branch_offset(branch_offset), .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               rwe;
    logic [4:0]         ra1, ra2, wa;
    logic               dwe;
    logic [DADDR_W-1:0] dra, dwa;
    logic [1:0]         alu;
    logic               sel, br;
    logic [BOFF_W-1:0]  boff;
    logic               ill;
  } bundle_t;

  bundle_t dut_b;
  assign dut_b = {reg_write_enable, reg_read_addr_1, reg_read_addr_2, reg_write_addr,
                  data_write_enable, data_read_addr, data_write_addr, alu_ctrl,
                  reg_write_select, branch, branch_offset, illegal};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Reference decode straight from the instruction table, using integer arithmetic.
  function automatic bundle_t ref_decode(input logic [31:0] w);
    bundle_t b;
    logic [6:0] op = w[6:0];
    logic [6:0] f7 = w[31:25];
    logic [2:0] f3 = w[14:12];
    int rd  = int'(w[11:7]);
    int rs1 = int'(w[19:15]);
    int rs2 = int'(w[24:20]);
    int ofs = int'({w[25], w[11:8]}) / 2;
    b = '0;
    if (op == 7'h03 && f3 == 3'd3) begin
      b.rwe = 1'b1;
      b.wa  = 5'(rd);
      b.dra = DADDR_W'((rs1 + rs2) % (1 << DADDR_W));
    end else if (op == 7'h23 && f3 == 3'd3) begin
      b.dwe = 1'b1;
      b.ra1 = 5'(rs2);
      b.dwa = DADDR_W'((rs1 + rd) % (1 << DADDR_W));
    end else if (op == 7'h33 && ((f7 == 7'h00 && (f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd0)) ||
                                 (f7 == 7'h20 && f3 == 3'd0))) begin
      b.rwe = 1'b1;
      b.sel = 1'b1;
      b.ra1 = 5'(rs1);
      b.ra2 = 5'(rs2);
      b.wa  = 5'(rd);
      if (f3 == 3'd7)       b.alu = 2'd0;
      else if (f3 == 3'd6)  b.alu = 2'd1;
      else if (f7 == 7'h00) b.alu = 2'd2;
      else                  b.alu = 2'd3;
    end else if (op == 7'h63 && f3 == 3'd0) begin
      b.br   = 1'b1;
      b.alu  = 2'd3;
      b.ra1  = 5'(rs1);
      b.ra2  = 5'(rs2);
      b.boff = BOFF_W'(ofs % (1 << BOFF_W));
    end else begin
      b.ill = 1'b1;
    end
    return b;
  endfunction

  // Model of the stage: a held bundle, a remaining-stall count and a "cleared" flag.
  bit      m_full  = 1'b0;
  bit      m_zero  = 1'b0;
  int      m_stall = 0;
  bundle_t m_b     = '0;
  logic    last_ir, last_ov;

  task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic fl, input logic rs);
    bundle_t dec;
    logic    hz, exp_ir;
    in_valid = iv; inst = ins; out_ready = ordy; flush = fl; rst = rs;
    #1;
    dec = ref_decode(ins);
    hz = iv && m_full && ordy && m_b.rwe && !m_b.sel && (m_b.wa != 5'd0) &&
         (dec.ra1 == m_b.wa || dec.ra2 == m_b.wa);
    if (rs || fl || m_stall > 0) exp_ir = 1'b0;
    else if (m_full)             exp_ir = ordy && !hz;
    else                         exp_ir = 1'b1;
    last_ir = in_ready;
    last_ov = out_valid;
    check("in_ready", 64'(in_ready), 64'(exp_ir));
    check("out_valid", 64'(out_valid), 64'(m_full));
    if (m_full || m_zero) check("bundle", 64'(dut_b), 64'(m_b));
    @(posedge clk);
    if (rs) begin
      m_full = 1'b0; m_stall = 0; m_b = '0; m_zero = 1'b1;
    end else if (fl) begin
      m_full = 1'b0; m_stall = 0;
    end else if (m_stall > 0) begin
      m_stall--;
    end else if (hz) begin
      m_full = 1'b0; m_stall = LOAD_LAT;
    end else if (exp_ir && iv) begin
      m_full = 1'b1; m_b = dec; m_zero = 1'b0;
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [4:0]  a, b, d;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: w = mk(7'h00, 5'($urandom_range(0, 31)), a, 3'd3, d, 7'h03);
      1: w = mk(7'h00, b, a, 3'd3, 5'($urandom_range(0, 31)), 7'h23);
      2: w = mk(7'h00, b, a, 3'd7, d, 7'h33);
      3: w = mk(7'h00, b, a, 3'd6, d, 7'h33);
      4: w = mk(7'h00, b, a, 3'd0, d, 7'h33);
      5: w = mk(7'h20, b, a, 3'd0, d, 7'h33);
      6: w = mk(7'($urandom_range(0, 127)), b, a, 3'd0, 5'($urandom_range(0, 31)), 7'h63);
      default: w = $urandom();
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADD_321 = 32'h002081B3;
  logic [31:0] ld5, ld0, add6_5, add6_0, sub_x;

  initial begin
    ld5    = mk(7'h00, 5'd15, 5'd20, 3'd3, 5'd5, 7'h03);
    ld0    = mk(7'h00, 5'd15, 5'd20, 3'd3, 5'd0, 7'h03);
    add6_5 = mk(7'h00, 5'd1, 5'd5, 3'd0, 5'd6, 7'h33);
    add6_0 = mk(7'h00, 5'd1, 5'd0, 3'd0, 5'd6, 7'h33);
    sub_x  = mk(7'h20, 5'd4, 5'd3, 3'd0, 5'd7, 7'h33);
    rst = 1'b1; in_valid = 1'b0; inst = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    m_zero = 1'b1;
    cycle(1'b1, ADD_321, 1'b1, 1'b0, 1'b1);
    check("rst_in_ready", 64'(last_ir), 64'd0);

    // add x3,x1,x2
    cycle(1'b1, ADD_321, 1'b1, 1'b0, 1'b0);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_alu", 64'(alu_ctrl), 64'd2);
    check("add_rd_addrs", 64'({reg_read_addr_1, reg_read_addr_2}), 64'({5'd1, 5'd2}));
    check("add_wr", 64'({reg_write_addr, reg_write_select}), 64'({5'd3, 1'b1}));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // ld with address wrap, then load-use hazard
    cycle(1'b1, ld5, 1'b1, 1'b0, 1'b0);
    check("ld_addr_wrap", 64'(data_read_addr), 64'd3);
    check("ld_ctrl", 64'({reg_write_enable, reg_write_select}), 64'({1'b1, 1'b0}));
    cycle(1'b1, add6_5, 1'b1, 1'b0, 1'b0);
    check("hazard_block", 64'(last_ir), 64'd0);
    for (int i = 0; i < LOAD_LAT; i++) begin
      cycle(1'b1, add6_5, 1'b1, 1'b0, 1'b0);
      check("stall_ready", 64'(last_ir), 64'd0);
      check("stall_valid", 64'(last_ov), 64'd0);
    end
    cycle(1'b1, add6_5, 1'b1, 1'b0, 1'b0);
    check("post_stall_accept", 64'(last_ir), 64'd1);
    check("post_stall_rd", 64'(reg_write_addr), 64'd6);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, ld0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, add6_0, 1'b1, 1'b0, 1'b0);
    check("x0_no_stall", 64'(last_ir), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // backpressure then back-to-back throughput
    cycle(1'b1, ADD_321, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, sub_x, 1'b0, 1'b0, 1'b0);
      check("bp_ready", 64'(last_ir), 64'd0);
      check("bp_hold_rd", 64'(reg_write_addr), 64'd3);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, mk(7'h00, 5'd2, 5'd1, 3'd0, 5'(10 + i), 7'h33), 1'b1, 1'b0, 1'b0);
      check("b2b_accept", 64'(last_ir), 64'd1);
      check("b2b_rd", 64'(reg_write_addr), 64'(10 + i));
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // flush in STALL, then in FULL
    cycle(1'b1, ld5, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, add6_5, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, add6_5, 1'b1, 1'b1, 1'b0);
    check("flush_stall_ov", 64'(out_valid), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_stall_empty", 64'(last_ir), 64'd1);
    cycle(1'b1, ADD_321, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, sub_x, 1'b1, 1'b1, 1'b0);
    check("flush_full_ov", 64'(out_valid), 64'd0);

    // illegal word
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check("illegal_flag", 64'(illegal), 64'd1);
    check("illegal_ctrl", 64'({reg_write_enable, data_write_enable, branch, alu_ctrl}), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // reset while stalled
    cycle(1'b1, ld5, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, add6_5, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, add6_5, 1'b1, 1'b0, 1'b1);
    check("rst_stall_ov", 64'(out_valid), 64'd0);
    check("rst_stall_fields", 64'(dut_b), 64'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_inst(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DADDR_W, 5, data-memory address width.
- BOFF_W, 5, branch offset width.
- LOAD_LAT, 1, bubble cycles inserted on a load-use hazard (range 1..7).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, inst is valid.
- in_ready, out, 1, stage accepts inst this cycle.
- inst, in, 32, RISC-V instruction word.
- flush, in, 1, discard held and incoming instruction.
- out_valid, out, 1, decoded bundle valid.
- out_ready, in, 1, downstream accepts bundle.
- reg_write_enable, out, 1, register-file write.
- reg_read_addr_1, out, 5, register read port 1.
- reg_read_addr_2, out, 5, register read port 2.
- reg_write_addr, out, 5, destination register.
- data_write_enable, out, 1, data-memory write.
- data_read_addr, out, DADDR_W, load address.
- data_write_addr, out, DADDR_W, store address.
- alu_ctrl, out, 2, 00 and, 01 or, 10 add, 11 sub.
- reg_write_select, out, 1, 1 = ALU result, 0 = memory.
- branch, out, 1, beq.
- branch_offset, out, BOFF_W, branch offset.
- illegal, out, 1, the held instruction is unsupported.

Function
REQ-003 Decode SHALL match on {inst[31:25], inst[14:12], inst[6:0]} as follows:
- ld: funct3 011, opcode 0000011.
- sd: funct3 011, opcode 0100011.
- and: 0000000/111/0110011.
- or: 0000000/110/0110011.
- add: 0000000/000/0110011.
- sub: 0100000/000/0110011.
- beq: funct3 000, opcode 1100011.
- Every other encoding: all control fields 0 and illegal=1.

REQ-004 ld SHALL produce:
- reg_write_enable=1, reg_write_addr=inst[11:7], reg_write_select=0.
- Read addresses 0.
- data_read_addr=(inst[19:15]+inst[24:20]) mod 2^DADDR_W.

REQ-005 sd SHALL produce:
- data_write_enable=1, reg_read_addr_1=inst[24:20], reg_read_addr_2=0.
- data_write_addr=(inst[19:15]+inst[11:7]) mod 2^DADDR_W.

REQ-006 R-type instructions SHALL produce:
- reg_write_enable=1, reg_write_select=1.
- reg_read_addr_1=inst[19:15], reg_read_addr_2=inst[24:20], reg_write_addr=inst[11:7].
- alu_ctrl per REQ-002.

REQ-007 beq SHALL produce:
- branch=1, alu_ctrl=11.
- Read addresses rs1/rs2.
- branch_offset=({inst[25],inst[11:8]}>>1), zero-extended or truncated to BOFF_W.

REQ-008 All fields not named for an instruction SHALL be 0.

REQ-009 Decoded fields SHALL be registered: one cycle latency from in_valid&&in_ready to out_valid.

REQ-010 The state machine SHALL have states EMPTY, FULL and STALL:
- EMPTY: in_ready=1, out_valid=0.
- FULL: out_valid=1, in_ready=out_ready; accept-and-send in the same cycle keeps FULL with new contents.
- STALL: out_valid=0, in_ready=0; a counter counts LOAD_LAT cycles, then the state goes to EMPTY.

REQ-011 A load-use hazard SHALL be detected under all of these conditions:
- in_valid=1.
- The bundle firing this cycle (out_valid&&out_ready) is ld with reg_write_addr!=0.
- That reg_write_addr equals a nonzero register the incoming instruction reads, per REQ-005/006/007.

On a hazard, in_ready SHALL be 0 and the next state SHALL be STALL.

REQ-012 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.

REQ-013 flush SHALL have these effects:
- Next state EMPTY, and the stall counter is cleared.
- The incoming inst is not captured, and out_valid=0 next cycle.
- flush has priority over accept, hazard and stall.

REQ-014 An illegal instruction SHALL be passed downstream with illegal=1. It is never a hazard source.

Reset
REQ-015 While rst=1 at a clock edge:
- The state SHALL become EMPTY and the stall counter 0.
- out_valid and all decoded fields SHALL be 0.
- in_ready SHALL be 0 during the rst cycle and 1 afterwards.

REQ-016 rst SHALL have priority over flush. An instruction in flight is lost.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_ctrl=10, read addrs 1/2, write addr 3, reg_write_select=1.
- ld x5 with rs1=20, offset field 15, DADDR_W=5 -> data_read_addr=3 (wrap), reg_write_enable=1, reg_write_select=0.
- ld x5 fires, then the next cycle offers add x6,x5,x1, LOAD_LAT=2 -> in_ready=0 for 2 cycles with out_valid=0, then the add is accepted; the same sequence with rd=x0 -> no stall.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; on release, back-to-back throughput is 1 per cycle.
- flush asserted in STALL, and separately in FULL -> next cycle EMPTY, out_valid=0, no capture.
- inst=0xFFFFFFFF -> illegal=1, all controls 0; rst mid-STALL -> EMPTY, all outputs 0.
